// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage of the 8-bit pipelined processor.
// Contents: datapath widths, opcode constants, FSM state encoding and the
// number of iterative multiply steps (two multiplier bits per step).
package exec_pkg;

  localparam int DATA_W    = 8;
  localparam int CODE_W    = 3;
  localparam int RD_W      = 2;
  localparam int MUL_STEPS = 4;
  localparam int CNT_W     = $clog2(MUL_STEPS);

  typedef logic [CODE_W-1:0] code_t;

  localparam code_t OP_ADD = 3'b000;
  localparam code_t OP_SUB = 3'b001;
  localparam code_t OP_AND = 3'b010;
  localparam code_t OP_OR  = 3'b011;
  localparam code_t OP_XOR = 3'b100;
  localparam code_t OP_SHL = 3'b101;
  localparam code_t OP_SHR = 3'b110;
  localparam code_t OP_MUL = 3'b111;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/execute_stage_if.sv
// Bundle of the decoded-instruction input side and the result/forwarding
// output side of the execute stage.
//   slave  : view taken by execute_stage (instruction in, result out)
//   master : view taken by the upstream decode / downstream consumers
interface execute_stage_if;

  logic                          in_valid;
  logic [exec_pkg::CODE_W-1:0]   in_code;
  logic [exec_pkg::DATA_W-1:0]   in_op_a;
  logic [exec_pkg::DATA_W-1:0]   in_op_b;
  logic [exec_pkg::RD_W-1:0]     in_rd;
  logic                          flush;

  logic                          stall_out;
  logic                          out_valid;
  logic [exec_pkg::DATA_W-1:0]   ALU_result;
  logic                          out_zero;
  logic [exec_pkg::RD_W-1:0]     out_rd;
  logic [exec_pkg::CODE_W-1:0]   Instruction_Codenn;
  logic [exec_pkg::CODE_W-1:0]   Instruction_Codennn;

  modport slave (
    input  in_valid, in_code, in_op_a, in_op_b, in_rd, flush,
    output stall_out, out_valid, ALU_result, out_zero, out_rd,
           Instruction_Codenn, Instruction_Codennn
  );

  modport master (
    output in_valid, in_code, in_op_a, in_op_b, in_rd, flush,
    input  stall_out, out_valid, ALU_result, out_zero, out_rd,
           Instruction_Codenn, Instruction_Codennn
  );

endinterface

// File: rtl/mul_iter.sv
// Iterative multiplier retiring two multiplier bits per cycle.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   start           : latch op_a/op_b, clear accumulator and counter, go busy
//   abort           : drop the multiply in progress
//   op_a, op_b      : multiplicand / multiplier
//   done            : combinational, high in the final step (counter = MUL_STEPS-1)
//   product         : low byte of accumulator plus the current step's partial
//                     products; valid while done is high
module mul_iter
  import exec_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  logic                  busy;
  logic [CNT_W-1:0]      cnt;
  logic [2*DATA_W-1:0]   acc;
  logic [2*DATA_W-1:0]   mcand;
  logic [DATA_W-1:0]     mplier;
  logic [1:0]            bits;
  logic [2*DATA_W-1:0]   pp;
  logic [2*DATA_W-1:0]   acc_sum;

  // Partial products for multiplier bits 2*cnt and 2*cnt+1.
  always_comb begin
    bits    = 2'(mplier >> {cnt, 1'b0});
    pp      = (bits[0] ? (mcand << {cnt, 1'b0}) : '0)
            + (bits[1] ? (mcand << {cnt, 1'b1}) : '0);
    acc_sum = acc + pp;
    product = acc_sum[DATA_W-1:0];
    done    = busy && (cnt == CNT_W'(MUL_STEPS - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      acc  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      acc  <= '0;
    end else if (abort || done) begin
      busy <= 1'b0;
      cnt  <= '0;
      acc  <= '0;
    end else if (busy) begin
      acc  <= acc_sum;
      cnt  <= cnt + 1'b1;
    end
  end

  // Operand latches are pure data; they are only read while busy.
  always_ff @(posedge clk) begin
    if (start) begin
      mcand  <= {{DATA_W{1'b0}}, op_a};
      mplier <= op_b;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: combinational ALU for single-cycle ops, iterative 4-step
// multiply, EX/WB result registers and a two-deep history of retired codes.
// Ports:
//   clk, reset : clock, synchronous active-high reset (clears all outputs)
//   ex         : execute_stage_if.slave
//                in : in_valid, in_code, in_op_a, in_op_b, in_rd, flush
//                out: stall_out, out_valid, ALU_result, out_zero, out_rd,
//                     Instruction_Codenn, Instruction_Codennn
module execute_stage
  import exec_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  execute_stage_if.slave ex
);

  state_t              state, state_next;
  logic                mul_start, mul_abort, mul_done;
  logic [DATA_W-1:0]   mul_product;
  logic [RD_W-1:0]     rd_p0;
  logic                retire;
  logic [DATA_W-1:0]   ret_result;
  code_t               ret_code;
  logic [RD_W-1:0]     ret_rd;
  logic [DATA_W-1:0]   alu_res;

  function automatic logic [DATA_W-1:0] alu(input code_t code,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    case (code)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SHL:  r = {a[DATA_W-2:0], 1'b0};
      OP_SHR:  r = {1'b0, a[DATA_W-1:1]};
      default: r = '0;   // MUL goes through mul_iter
    endcase
    return r;
  endfunction

  assign alu_res = alu(ex.in_code, ex.in_op_a, ex.in_op_b);

  mul_iter u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .abort   (mul_abort),
    .op_a    (ex.in_op_a),
    .op_b    (ex.in_op_b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state and retire selection. Inputs are ignored while busy except
  // flush, which abandons the multiply.
  always_comb begin
    state_next = state;
    mul_start  = 1'b0;
    mul_abort  = 1'b0;
    retire     = 1'b0;
    ret_result = alu_res;
    ret_code   = ex.in_code;
    ret_rd     = ex.in_rd;
    case (state)
      ST_IDLE: begin
        if (ex.in_valid && !ex.flush) begin
          if (ex.in_code == OP_MUL) begin
            mul_start  = 1'b1;
            state_next = ST_MUL_BUSY;
          end else begin
            retire = 1'b1;
          end
        end
      end
      ST_MUL_BUSY: begin
        if (ex.flush) begin
          mul_abort  = 1'b1;
          state_next = ST_IDLE;
        end else if (mul_done) begin
          retire     = 1'b1;
          ret_result = mul_product;
          ret_code   = OP_MUL;
          ret_rd     = rd_p0;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Destination of the multiply in flight.
  always_ff @(posedge clk) begin
    if (mul_start) rd_p0 <= ex.in_rd;
  end

  // EX/WB boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      ex.out_valid           <= 1'b0;
      ex.ALU_result          <= '0;
      ex.out_zero            <= 1'b0;
      ex.out_rd              <= '0;
      ex.Instruction_Codenn  <= '0;
      ex.Instruction_Codennn <= '0;
    end else begin
      ex.out_valid <= retire;
      if (retire) begin
        ex.ALU_result          <= ret_result;
        ex.out_zero            <= (ret_result == '0);
        ex.out_rd              <= ret_rd;
        ex.Instruction_Codennn <= ex.Instruction_Codenn;
        ex.Instruction_Codenn  <= ret_code;
      end
    end
  end

  // Decode of a register only; no path from inputs.
  assign ex.stall_out = (state == ST_MUL_BUSY);

endmodule
